mem_stage_ws: RTL and testbench
===============================

Name: mem_stage_ws

Overview:
Parametrised next-generation memory stage for the 5-stage MIPS pipeline. It sits between the EX/MEM register and the writeback stage, and combines data memory with the MEM/WB pipeline register. It adds byte, halfword and word accesses with optional sign extension, misalignment detection, and a configurable number of memory wait states that stall upstream. It also accepts a flush that inserts a bubble into MEM/WB.

Parameters:
DEPTH, 256, data memory size in 32-bit words; power of two, at least 2.
WAIT_STATES, 0, extra cycles each load or store occupies the stage (0..15).
WB_W, 2, width of the writeback control bundle.
REG_W, 5, width of the destination register index.

Ports:
CLK  input  1  pipeline clock, rising edge.
RST  input  1  asynchronous, active-high reset.
in_valid  input  1  stage holds a real instruction (0 = bubble).
control_wb  input  WB_W  writeback control passed through to WB.
address  input  32  ALU result: memory byte address, also forwarded as ALU result.
write_data  input  32  store data, right-aligned in the low bits.
write_register  input  REG_W  destination register index.
mem_read  input  1  load request.
mem_write  input  1  store request.
mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
mem_signed  input  1  1 = sign-extend loaded byte/half, 0 = zero-extend.
flush  input  1  discard the current instruction.
stall_out  output  1  upstream must hold its inputs stable this cycle.
wb_valid  output  1  MEM/WB register holds a real instruction.
control_wb_out  output  WB_W  registered writeback control.
read_data_out  output  32  registered, extended load data.
alu_result_out  output  32  registered copy of address.
write_reg_out  output  REG_W  registered destination register.
misalign_out  output  1  registered alignment fault flag.

Behaviour:
- Reset (async, RST=1): every MEM/WB output goes to 0, the FSM goes to IDLE, the wait counter goes to 0, and any pending store is discarded. Memory contents are not reset.
- Definitions:
  - access = in_valid & (mem_read | mem_write).
  - Word index = address[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses alias and wrap.
  - Memory is little-endian: byte lane k = address[1:0].
- Misaligned: half with address[0]=1, or word with address[1:0]!=0.
  - The store is suppressed and read_data_out=0.
  - control_wb_out is forced to 0 and misalign_out=1.
  - wb_valid=1 and alu_result_out/write_reg_out still carry their values.
- Loads:
  - Byte and half loads select the lane and extend according to mem_signed.
  - Word loads pass through.
  - If mem_read and mem_write are both 1, the access is treated as a store and read_data_out=0.
- Stores write only the addressed lanes: byte→1 lane, half→2 lanes, word→all 4 lanes.
- FSM states: IDLE, WAIT; counter cnt of 4 bits.
  - IDLE: if access and WAIT_STATES>0 and no flush, set stall_out=1, cnt<=1, go to WAIT.
  - IDLE, otherwise: complete the instruction this cycle.
  - WAIT: stall_out=1 while cnt<WAIT_STATES, and cnt increments each cycle.
  - WAIT, when cnt==WAIT_STATES: stall_out=0, the instruction completes, cnt<=0, go to IDLE.
  - stall_out is combinational from state, cnt, in_valid and access; it is never asserted when WAIT_STATES=0.
- Completion edge:
  - The store commits to memory.
  - MEM/WB loads {1, control_wb, extended data, address, write_register, misalign}.
  - With WAIT_STATES=0, load data is visible on read_data_out one cycle after the inputs are presented.
  - The total latency is 1+WAIT_STATES cycles.
- Stall cycles: MEM/WB loads a bubble (wb_valid=0, control_wb_out=0, misalign_out=0, other fields 0).
- Non-memory instructions (in_valid=1, no access) complete in 1 cycle with no stall, and read_data_out=0.
- in_valid=0: MEM/WB loads a bubble.
- Flush (any state):
  - MEM/WB loads a bubble, the store is suppressed, and the FSM returns to IDLE with cnt=0.
  - Flush on the completion cycle: flush wins and memory is unchanged.
- Inputs that change during WAIT are a protocol violation; the block is not required to behave correctly in that case.

Test Plan:
1. WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 → read_data_out=0xDEADBEEF one cycle later, wb_valid=1, stall_out never 1.
2. Byte/half lanes: SB 0x80 @0x21, then LB signed @0x21 → 0xFFFFFF80; LBU → 0x00000080; SH 0x8001 @0x22, then LH → 0xFFFF8001; other bytes of word 0x20 unchanged.
3. Misaligned: LW @0x13 → misalign_out=1, control_wb_out=0, read_data_out=0; SH @0x31 → memory word 0x30 unchanged.
4. WAIT_STATES=3: LW presented at cycle T → stall_out=1 in T..T+2 and 0 at T+3; bubbles in MEM/WB for three cycles, then valid data after the T+3 edge.
5. Flush at the WAIT completion cycle of SW 0x12345678 @0x40 → bubble, memory @0x40 keeps its old value, FSM in IDLE; next instruction proceeds without stall.
6. RST pulsed mid-WAIT (asynchronous, not clock-aligned) → outputs 0 immediately, stall_out=0, pending store not written; the DEPTH=256 aliasing check of @0x400 and @0x0 hitting the same word passes.

Source files
------------

// File: rtl/mem_stage_ws.sv
// MIPS memory stage with data memory, byte/half/word access, misalignment detection,
// configurable wait states that stall upstream, and the MEM/WB pipeline register.
module mem_stage_ws #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WB_W        = 2,
    parameter int unsigned REG_W       = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [WB_W-1:0]   control_wb,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    input  logic [REG_W-1:0]  write_register,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic              flush,
    output logic              stall_out,
    output logic              wb_valid,
    output logic [WB_W-1:0]   control_wb_out,
    output logic [31:0]       read_data_out,
    output logic [31:0]       alu_result_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic              misalign_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic          access;
    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic          complete;
    logic          we;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rd_word;
    logic [15:0]   lane_half;
    logic [31:0]   load_data;

    // Access decode, completion and stall
    always_comb begin
        access    = in_valid & (mem_read | mem_write);
        idx       = address[AW+1:2];
        lane      = address[1:0];
        is_half   = (mem_size == 2'b01);
        is_word   = mem_size[1];
        misalign  = access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
        complete  = ~flush & (((state == IDLE) & ((WS == 4'd0) | ~access)) |
                              ((state == WAIT) & (cnt == WS)));
        we        = complete & in_valid & mem_write & ~misalign;
        stall_out = ~RST & (WS != 4'd0) &
                    (((state == IDLE) & access) | ((state == WAIT) & (cnt != WS)));
    end

    // Lane enables and store data placement
    always_comb begin
        be = 4'b1111;
        case (mem_size)
            2'b00:   be = 4'(4'b0001 << lane);
            2'b01:   be = 4'(4'b0011 << lane);
            default: be = 4'b1111;
        endcase
        wdata_sh = write_data << {lane, 3'b000};
    end

    // Load lane select and extension; stores and faults return zero
    always_comb begin
        rd_word   = mem[idx];
        lane_half = 16'(rd_word >> {lane, 3'b000});
        case (mem_size)
            2'b00:   load_data = mem_signed ? {{24{lane_half[7]}}, lane_half[7:0]}
                                            : {24'd0, lane_half[7:0]};
            2'b01:   load_data = mem_signed ? {{16{lane_half[15]}}, lane_half}
                                            : {16'd0, lane_half};
            default: load_data = rd_word;
        endcase
        if (!mem_read || mem_write || misalign) begin
            load_data = 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (we && be[k]) begin
                mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    // Wait-state FSM and MEM/WB register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            wb_valid       <= 1'b0;
            control_wb_out <= '0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            write_reg_out  <= '0;
            misalign_out   <= 1'b0;
        end else begin
            if (flush) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (access && (WS != 4'd0)) begin
                            state <= WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                    WAIT: begin
                        if (cnt == WS) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end

            if (complete && in_valid) begin
                wb_valid       <= 1'b1;
                control_wb_out <= misalign ? '0 : control_wb;
                read_data_out  <= load_data;
                alu_result_out <= address;
                write_reg_out  <= write_register;
                misalign_out   <= misalign;
            end else begin
                wb_valid       <= 1'b0;
                control_wb_out <= '0;
                read_data_out  <= 32'd0;
                alu_result_out <= 32'd0;
                write_reg_out  <= '0;
                misalign_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench for mem_stage_ws: a zero-wait instance and a three-wait-state instance
// share one input bundle; each scenario task checks its own expectations inline.
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  control_wb = 2'b00;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [4:0]  write_register = 5'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b10;
    logic        mem_signed = 1'b0;
    logic        flush = 1'b0;

    logic        stall0, wbv0, mis0, stall3, wbv3, mis3;
    logic [1:0]  cwb0, cwb3;
    logic [31:0] rd0, alu0, rd3, alu3;
    logic [4:0]  wreg0, wreg3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_ws #(.DEPTH(256), .WAIT_STATES(0), .WB_W(2), .REG_W(5)) dut0 (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .control_wb(control_wb),
        .address(address), .write_data(write_data), .write_register(write_register),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .flush(flush), .stall_out(stall0), .wb_valid(wbv0),
        .control_wb_out(cwb0), .read_data_out(rd0), .alu_result_out(alu0),
        .write_reg_out(wreg0), .misalign_out(mis0)
    );

    mem_stage_ws #(.DEPTH(256), .WAIT_STATES(3), .WB_W(2), .REG_W(5)) dut3 (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .control_wb(control_wb),
        .address(address), .write_data(write_data), .write_register(write_register),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .flush(flush), .stall_out(stall3), .wb_valid(wbv3),
        .control_wb_out(cwb3), .read_data_out(rd3), .alu_result_out(alu3),
        .write_reg_out(wreg3), .misalign_out(mis3)
    );

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] wreg, input logic [1:0] cwb);
        in_valid = v; mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
        address = a; write_data = wd; write_register = wreg; control_wb = cwb; flush = 1'b0;
    endtask

    // One zero-wait instruction: present at negedge, sample just after the next rising edge
    task automatic op0(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] wreg, input logic [1:0] cwb);
        @(negedge clk);
        drive(v, rd, wr, sz, sg, a, wd, wreg, cwb);
        @(posedge clk);
        #1;
    endtask

    // One full three-wait-state transaction held for four edges
    task automatic run3(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] wreg, input logic [1:0] cwb);
        @(negedge clk);
        drive(1'b1, rd, wr, sz, sg, a, wd, wreg, cwb);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_run++;
        if ({wbv0, cwb0, rd0, alu0, wreg0, mis0} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h want 0", {wbv0, cwb0, rd0, alu0, wreg0, mis0});
        end
        n_run++;
        if ({wbv3, cwb3, rd3, alu3, wreg3, mis3, stall3, stall0} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: got %h want 0",
                     {wbv3, cwb3, rd3, alu3, wreg3, mis3, stall3, stall0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd5, 2'b01);
        #1;
        n_run++;
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b want 0", stall0); end
        @(posedge clk);
        #1;
        n_run++;
        if ({wbv0, cwb0, rd0, alu0, wreg0} !== {1'b1, 2'b01, 32'd0, 32'h10, 5'd5}) begin
            n_fail++;
            $display("FAIL sw_wb: got %b %b %h %h %0d want 1 01 0 10 5", wbv0, cwb0, rd0, alu0, wreg0);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, 2'b11);
        #1;
        n_run++;
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lw_stall: got %b want 0", stall0); end
        @(posedge clk);
        #1;
        n_run++;
        if ({wbv0, cwb0, rd0, wreg0, mis0} !== {1'b1, 2'b11, 32'hDEADBEEF, 5'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_wb: got %b %b %h %0d %b want 1 11 deadbeef 7 0",
                     wbv0, cwb0, rd0, wreg0, mis0);
        end
    endtask

    task automatic test_lanes();
        op0(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd1, 2'b01);
        op0(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, 5'd1, 2'b01);
        op0(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 5'd2, 2'b11);
        n_run++;
        if (rd0 !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", rd0); end
        op0(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 5'd2, 2'b11);
        n_run++;
        if (rd0 !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", rd0); end
        op0(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD8001, 5'd1, 2'b01);
        op0(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 5'd3, 2'b11);
        n_run++;
        if (rd0 !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", rd0); end
        op0(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd3, 2'b11);
        n_run++;
        if (rd0 !== 32'h80018044) begin n_fail++; $display("FAIL lanes_word: got %h want 80018044", rd0); end
        op0(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 5'd3, 2'b11);
        n_run++;
        if (rd0 !== 32'h00008044) begin n_fail++; $display("FAIL lhu_low: got %h want 00008044", rd0); end
        op0(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 5'd3, 2'b11);
        n_run++;
        if (rd0 !== 32'h00000044) begin n_fail++; $display("FAIL lb_pos: got %h want 00000044", rd0); end
    endtask

    task automatic test_misalign();
        op0(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 5'd9, 2'b11);
        n_run++;
        if ({wbv0, mis0, cwb0, rd0, alu0, wreg0} !== {1'b1, 1'b1, 2'b00, 32'd0, 32'h13, 5'd9}) begin
            n_fail++;
            $display("FAIL lw_misalign: got %b %b %b %h %h %0d want 1 1 00 0 13 9",
                     wbv0, mis0, cwb0, rd0, alu0, wreg0);
        end
        op0(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 5'd1, 2'b01);
        op0(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF, 5'd1, 2'b01);
        n_run++;
        if ({mis0, cwb0} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL sh_misalign: got %b %b want 1 00", mis0, cwb0);
        end
        op0(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 5'd4, 2'b11);
        n_run++;
        if ({rd0, mis0} !== {32'hCAFEF00D, 1'b0}) begin
            n_fail++;
            $display("FAIL sh_suppressed: got %h %b want cafef00d 0", rd0, mis0);
        end
    endtask

    task automatic test_nonmem_bubble();
        op0(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h1235, 32'hFFFFFFFF, 5'd3, 2'b10);
        n_run++;
        if ({wbv0, cwb0, rd0, alu0, wreg0, mis0} !== {1'b1, 2'b10, 32'd0, 32'h1235, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL nonmem: got %b %b %h %h %0d %b want 1 10 0 1235 3 0",
                     wbv0, cwb0, rd0, alu0, wreg0, mis0);
        end
        op0(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd8, 2'b11);
        n_run++;
        if ({wbv0, cwb0, rd0, alu0, wreg0} !== 72'd0) begin
            n_fail++;
            $display("FAIL bubble: got %b %b %h %h %0d want all 0", wbv0, cwb0, rd0, alu0, wreg0);
        end
    endtask

    task automatic test_alias();
        op0(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5A5A5, 5'd1, 2'b01);
        op0(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd2, 2'b11);
        n_run++;
        if (rd0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL alias: got %h want a5a5a5a5", rd0); end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
        rst = 1'b1;
        #1 rst = 1'b0;
        run3(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0BADF00D, 5'd4, 2'b01);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 5'd6, 2'b11);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (stall3 !== (i < 3)) begin
                n_fail++;
                $display("FAIL ws_stall_%0d: got %b want %b", i, stall3, (i < 3));
            end
            @(posedge clk);
            #1;
            n_run++;
            if (wbv3 !== (i == 3)) begin
                n_fail++;
                $display("FAIL ws_valid_%0d: got %b want %b", i, wbv3, (i == 3));
            end
            if (i < 3) @(negedge clk);
        end
        n_run++;
        if ({rd3, cwb3, wreg3} !== {32'h0BADF00D, 2'b11, 5'd6}) begin
            n_fail++;
            $display("FAIL ws_data: got %h %b %0d want 0badf00d 11 6", rd3, cwb3, wreg3);
        end
    endtask

    task automatic test_flush();
        run3(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 5'd1, 2'b01);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 5'd1, 2'b01);
        for (int i = 0; i < 3; i++) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_run++;
        if (stall3 !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall3); end
        @(posedge clk);
        #1;
        n_run++;
        if ({wbv3, cwb3, alu3} !== 35'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got %b %b %h want 0 00 0", wbv3, cwb3, alu3);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd2, 2'b11);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (stall3 !== (i < 3)) begin
                n_fail++;
                $display("FAIL post_flush_stall_%0d: got %b want %b", i, stall3, (i < 3));
            end
            @(posedge clk);
            if (i < 3) @(negedge clk);
        end
        #1;
        n_run++;
        if ({wbv3, rd3} !== {1'b1, 32'h11111111}) begin
            n_fail++;
            $display("FAIL flush_mem: got %b %h want 1 11111111", wbv3, rd3);
        end
    endtask

    task automatic test_reset_midwait();
        run3(1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h66666666, 5'd1, 2'b01);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h77777777, 5'd2, 2'b01);
        @(posedge clk);
        #1;
        n_run++;
        if (wbv0 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", wbv0); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_run++;
        if ({wbv0, cwb0, alu0, wreg0, wbv3, stall3} !== 42'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b %b %h %0d %b %b want all 0",
                     wbv0, cwb0, alu0, wreg0, wbv3, stall3);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
        #2 rst = 1'b0;
        run3(1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 5'd3, 2'b11);
        n_run++;
        if ({wbv3, rd3} !== {1'b1, 32'h66666666}) begin
            n_fail++;
            $display("FAIL reset_store_dropped: got %b %h want 1 66666666", wbv3, rd3);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_misalign();
        test_nonmem_bubble();
        test_alias();
        test_wait_states();
        test_flush();
        test_reset_midwait();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
